// File: rtl/softmax_norm.sv
// Softmax normalization back end: aligns 16 lanes of Q1.7 numerators to the final row max and
// divides each by its lane denominator with a shared 8-step restoring divider, giving Q0.8 results.
module softmax_norm #(
    parameter int COLS = 16
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_denom_valid,
    input  logic [479:0] i_runmax,
    input  logic [143:0] i_denom,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [127:0] i_y,
    input  logic [479:0] i_tag,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [127:0] o_p,
    output logic         o_last
);
    localparam int LANES = 16;
    localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;

    typedef enum logic [1:0] {
        S_WAIT,
        S_IDLE,
        S_DIV,
        S_OUT
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [CW-1:0] r_col_cnt;
    logic [2:0]    r_step_cnt;

    logic w_load;
    logic w_accept;
    logic w_step;
    logic w_out_hs;
    logic w_row_end;
    logic w_ready;
    logic w_valid;

    assign w_row_end = (r_col_cnt == CW'(COLS - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_WAIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ready      = 1'b0;
        w_valid      = 1'b0;
        w_load       = 1'b0;
        w_accept     = 1'b0;
        w_step       = 1'b0;
        w_out_hs     = 1'b0;
        case (r_state)
            S_WAIT: begin
                if (i_denom_valid) begin
                    w_load       = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            S_IDLE: begin
                w_ready = 1'b1;
                if (i_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = S_DIV;
                end
            end
            S_DIV: begin
                w_step = 1'b1;
                if (r_step_cnt == 3'd7) begin
                    w_state_next = S_OUT;
                end
            end
            S_OUT: begin
                w_valid = 1'b1;
                if (i_ready) begin
                    w_out_hs     = 1'b1;
                    w_state_next = w_row_end ? S_WAIT : S_IDLE;
                end
            end
            default: w_state_next = S_WAIT;
        endcase
    end

    assign o_ready = w_ready;
    assign o_valid = w_valid;
    assign o_last  = w_valid & w_row_end;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_col_cnt  <= '0;
            r_step_cnt <= '0;
        end else begin
            if (w_load) begin
                r_col_cnt <= '0;
            end else if (w_out_hs) begin
                r_col_cnt <= w_row_end ? '0 : r_col_cnt + CW'(1);
            end
            if (w_accept) begin
                r_step_cnt <= '0;
            end else if (w_step) begin
                r_step_cnt <= r_step_cnt + 3'd1;
            end
        end
    end

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic signed [29:0] r_fmax;
        logic [8:0]         r_d;
        logic [9:0]         r_rem;
        logic [7:0]         r_q;
        logic               r_sat;

        logic [29:0] w_tag;
        logic [30:0] w_diff;
        logic [7:0]  w_y;
        logic [7:0]  w_n;
        logic [8:0]  w_n2;
        logic        w_sat;
        logic [9:0]  w_shl;
        logic [9:0]  w_sub;
        logic        w_ge;

        assign w_tag  = i_tag[30*gi +: 30];
        assign w_y    = i_y[8*gi +: 8];
        assign w_diff = {r_fmax[29], r_fmax} - {w_tag[29], w_tag};

        // A tag above the final max cannot happen in a consistent row; pass the numerator through.
        always_comb begin
            w_n = w_y;
            if (w_diff[30]) begin
                w_n = w_y;
            end else if (|w_diff[29:3]) begin
                w_n = '0;
            end else begin
                w_n = w_y >> w_diff[2:0];
            end
        end

        assign w_n2  = {w_n, 1'b0};
        assign w_sat = (r_d == '0) || (w_n2 >= r_d);
        assign w_shl = {r_rem[8:0], 1'b0};
        // Bit 9 shifted out means the true shifted remainder is at least 1024, hence >= d.
        assign w_ge  = r_rem[9] || (w_shl >= {1'b0, r_d});
        assign w_sub = w_shl - {1'b0, r_d};

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_fmax <= '0;
                r_d    <= '0;
                r_rem  <= '0;
                r_q    <= '0;
                r_sat  <= 1'b0;
            end else begin
                if (w_load) begin
                    r_fmax <= i_runmax[30*gi +: 30];
                    r_d    <= i_denom[9*gi +: 9];
                end
                if (w_accept) begin
                    r_rem <= {1'b0, w_n2};
                    r_q   <= '0;
                    r_sat <= w_sat;
                end else if (w_step) begin
                    r_rem <= w_ge ? w_sub : w_shl;
                    r_q   <= {r_q[6:0], w_ge};
                end
            end
        end

        assign o_p[8*gi +: 8] = (r_d == '0) ? 8'h00 : (r_sat ? 8'hFF : r_q);
    end

endmodule

// File: tb/tb_softmax_norm.sv
// Table-driven bench for softmax_norm: rows of vectors with expected probabilities queued on send
// and compared on each output handshake, plus hand-written backpressure, row-end and reset sequences.
module tb_softmax_norm;
    localparam int COLS = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         denom_valid = 1'b0;
    logic [479:0] runmax = '0;
    logic [143:0] denom = '0;
    logic         in_valid = 1'b0;
    logic         o_ready;
    logic [127:0] y = '0;
    logic [479:0] tag = '0;
    logic         o_valid;
    logic         out_ready = 1'b0;
    logic [127:0] o_p;
    logic         o_last;

    softmax_norm #(.COLS(COLS)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_denom_valid(denom_valid),
        .i_runmax     (runmax),
        .i_denom      (denom),
        .i_valid      (in_valid),
        .o_ready      (o_ready),
        .i_y          (y),
        .i_tag        (tag),
        .o_valid      (o_valid),
        .i_ready      (out_ready),
        .o_p          (o_p),
        .o_last       (o_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] y;
        logic [479:0] tag;
        logic [127:0] exp;
        int           bp;
        bit           pulse;
    } vec_t;

    vec_t         tbl[COLS];
    logic [127:0] sb[$];
    int           fmax_c[16];
    int           d_c[16];
    int           n_pass = 0;
    int           n_tot = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: align by the max difference, then floor(512*n/d) with saturation.
    function automatic logic [7:0] ref_p(input int yv, input int fm, input int tg, input int d);
        longint diff;
        longint n;
        diff = longint'(fm) - longint'(tg);
        if (diff < 0) n = yv;
        else if (diff >= 8) n = 0;
        else n = yv / (1 << diff);
        if (d == 0) return 8'd0;
        if (2 * n >= d) return 8'd255;
        return 8'((512 * n) / d);
    endfunction

    task automatic set_garbage();
        for (int k = 0; k < 16; k++) begin
            runmax[30*k +: 30] = '0;
            denom[9*k +: 9]    = 9'd1;
        end
    endtask

    task automatic scramble_inputs();
        for (int k = 0; k < 16; k++) begin
            y[8*k +: 8]    = 8'($urandom);
            tag[30*k +: 30] = 30'($urandom);
        end
    endtask

    task automatic load_row();
        for (int k = 0; k < 16; k++) begin
            runmax[30*k +: 30] = 30'(fmax_c[k]);
            denom[9*k +: 9]    = 9'(d_c[k]);
        end
        denom_valid = 1'b1;
        @(negedge clk);
        denom_valid = 1'b0;
        set_garbage();
        chk("ready_after_load", o_ready, 1);
    endtask

    task automatic build_random(input int i);
        int yv;
        int tv;
        tbl[i].bp    = 0;
        tbl[i].pulse = 1'b0;
        for (int k = 0; k < 16; k++) begin
            yv = int'($urandom_range(0, 255));
            tv = fmax_c[k] - (int'($urandom_range(0, 11)) - 3);
            tbl[i].y[8*k +: 8]     = 8'(yv);
            tbl[i].tag[30*k +: 30] = 30'(tv);
            tbl[i].exp[8*k +: 8]   = ref_p(yv, fmax_c[k], tv, d_c[k]);
        end
    endtask

    task automatic send(input vec_t v);
        int t = 0;
        while (!o_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("ready_before_send", o_ready, 1);
        y        = v.y;
        tag      = v.tag;
        in_valid = 1'b1;
        sb.push_back(v.exp);
        @(negedge clk);
        in_valid = 1'b0;
        scramble_inputs();
    endtask

    // Entered at the first falling edge after acceptance; e counts edges with acceptance as edge 1.
    task automatic recv(input int bp, input bit pulse, input bit exp_last, input int col);
        int           e = 1;
        bit           stable = 1'b1;
        logic [127:0] p0;
        logic [127:0] exp;
        while (!o_valid && e < 40) begin
            if (pulse && e == 3) begin
                set_garbage();
                denom_valid = 1'b1;
            end else begin
                denom_valid = 1'b0;
            end
            @(negedge clk);
            e++;
        end
        denom_valid = 1'b0;
        chk("valid_rise", o_valid, 1);
        chk("latency", e, 9);
        p0 = o_p;
        for (int c = 0; c < bp; c++) begin
            in_valid = 1'b1;
            if (c == 2) begin
                set_garbage();
                denom_valid = 1'b1;
            end
            @(negedge clk);
            denom_valid = 1'b0;
            if (o_p !== p0 || o_valid !== 1'b1 || o_ready !== 1'b0) stable = 1'b0;
        end
        in_valid = 1'b0;
        if (bp > 0) chk("backpressure_hold", stable, 1);
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 0, 1);
            exp = '0;
        end else begin
            exp = sb.pop_front();
        end
        chk("o_p", o_p, exp);
        chk("o_last", o_last, exp_last);
        $display("col %0d: o_p=%h last=%0b latency=%0d", col, o_p, o_last, e);
        out_ready = 1'b1;
        if (exp_last) begin
            set_garbage();
            denom_valid = 1'b1;
        end
        @(negedge clk);
        out_ready   = 1'b0;
        denom_valid = 1'b0;
        chk("valid_drop", o_valid, 0);
        chk("ready_after_out", o_ready, !exp_last);
    endtask

    task automatic run_row();
        bit quiet = 1'b1;
        for (int i = 0; i < COLS; i++) begin
            if (tbl[i].pulse) begin
                set_garbage();
                denom_valid = 1'b1;
                @(negedge clk);
                denom_valid = 1'b0;
            end
            send(tbl[i]);
            recv(tbl[i].bp, tbl[i].pulse, i == COLS - 1, i);
        end
        repeat (6) begin
            @(negedge clk);
            if (o_ready !== 1'b0 || o_valid !== 1'b0) quiet = 1'b0;
        end
        chk("wait_after_row", quiet, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   quiet;
        vec_t v;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_ready", o_ready, 0);
        chk("rst_valid", o_valid, 0);
        chk("rst_last", o_last, 0);
        chk("rst_p", o_p, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("wait_state_ready", o_ready, 0);

        // Row A: basic divide on all lanes, then random vectors; backpressure on column 3.
        for (int k = 0; k < 16; k++) begin
            fmax_c[k] = 5;
            d_c[k]    = 384;
        end
        for (int i = 0; i < COLS; i++) build_random(i);
        for (int k = 0; k < 16; k++) begin
            tbl[0].y[8*k +: 8]     = 8'd128;
            tbl[0].tag[30*k +: 30] = 30'd5;
            tbl[0].exp[8*k +: 8]   = 8'd170;
        end
        tbl[3].bp = 5;
        load_row();
        run_row();

        // Row B: per-lane corners in column 0; stray denominator pulses mid-row must be ignored.
        for (int k = 0; k < 16; k++) begin
            fmax_c[k] = (k < 5) ? 5 : ((k % 2) ? -1000 * k : 123456 * k);
            d_c[k]    = (k < 3) ? 256 : (k == 3) ? 0 : (k == 4) ? 200 : 100 + 25 * k;
        end
        for (int i = 0; i < COLS; i++) build_random(i);
        for (int k = 0; k < 16; k++) begin
            tbl[0].y[8*k +: 8]     = 8'd100;
            tbl[0].tag[30*k +: 30] = 30'(fmax_c[k]);
            tbl[0].exp[8*k +: 8]   = ref_p(100, fmax_c[k], fmax_c[k], d_c[k]);
        end
        tbl[0].y[7:0]    = 8'd128; tbl[0].tag[29:0]   = 30'd3;  tbl[0].exp[7:0]   = 8'd64;
        tbl[0].y[15:8]   = 8'd128; tbl[0].tag[59:30]  = -30'sd3; tbl[0].exp[15:8]  = 8'd0;
        tbl[0].y[23:16]  = 8'd64;  tbl[0].tag[89:60]  = 30'd7;  tbl[0].exp[23:16] = 8'd128;
        tbl[0].y[31:24]  = 8'd128; tbl[0].tag[119:90] = 30'd5;  tbl[0].exp[31:24] = 8'd0;
        tbl[0].y[39:32]  = 8'd128; tbl[0].tag[149:120] = 30'd5; tbl[0].exp[39:32] = 8'd255;
        tbl[6].pulse = 1'b1;
        tbl[9].bp    = 4;
        load_row();
        run_row();

        // Reset at divider step 4: everything clears and no output appears afterwards.
        for (int k = 0; k < 16; k++) begin
            fmax_c[k] = 5;
            d_c[k]    = 384;
            v.y[8*k +: 8]     = 8'd128;
            v.tag[30*k +: 30] = 30'd5;
            v.exp[8*k +: 8]   = 8'd170;
        end
        v.bp    = 0;
        v.pulse = 1'b0;
        load_row();
        send(v);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", o_valid, 0);
        chk("midrst_ready", o_ready, 0);
        chk("midrst_last", o_last, 0);
        chk("midrst_p", o_p, 0);
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        quiet = 1'b1;
        repeat (15) begin
            @(negedge clk);
            if (o_valid !== 1'b0 || o_ready !== 1'b0) quiet = 1'b0;
        end
        chk("no_output_after_reset", quiet, 1);
        load_row();
        send(v);
        recv(0, 1'b0, 1'b0, 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
